// File: rtl/pipe_run_ctrl.sv
// Run controller for a pipelined CPU: IDLE -> FLUSH -> RUN -> DONE with saturating run statistics.
// Optional watchdog enabled by defining PIPE_RUN_TIMEOUT_EN.
module pipe_run_ctrl #(
  parameter int STAGES  = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [2:0]       W_stat_i,
  input  logic [3:0]       W_icode_i,
  input  logic             D_stall_i,
  input  logic             D_bubble_i,
  input  logic             E_bubble_i,
  input  logic             M_bubble_i,
  output logic             run_o,
  output logic             flush_o,
  output logic             done_o,
  output logic [1:0]       state_o,
  output logic [2:0]       final_stat_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FLUSH = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [3:0] FLUSH_LAST = 4'(STAGES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [2:0]       final_q, final_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic term, retire, any_bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  assign term       = (W_stat_i == 3'd2) || (W_stat_i == 3'd3) || (W_stat_i == 3'd4);
  assign retire     = ((W_stat_i == 3'd1) && (W_icode_i != 4'h1)) || (W_stat_i == 3'd2);
  assign any_bubble = D_bubble_i || E_bubble_i || M_bubble_i;

`ifdef PIPE_RUN_TIMEOUT_EN
  logic timeout_hit;
  // The watchdog fires on the RUN cycle that brings cycle_cnt_o up to TIMEOUT.
  assign timeout_hit = (64'(cycle_q) == 64'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    final_d     = final_q;
    cycle_d     = cycle_q;
    instr_d     = instr_q;
    stall_d     = stall_q;
    bubble_d    = bubble_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_FLUSH;
          flush_cnt_d = 4'd0;
          final_d     = 3'd0;
          cycle_d     = '0;
          instr_d     = '0;
          stall_d     = '0;
          bubble_d    = '0;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = S_RUN;
          flush_cnt_d = 4'd0;
        end else begin
          flush_cnt_d = flush_cnt_q + 4'd1;
        end
      end
      default: begin
        cycle_d  = sat_inc(cycle_q, 1'b1);
        instr_d  = sat_inc(instr_q, retire);
        stall_d  = sat_inc(stall_q, D_stall_i);
        bubble_d = sat_inc(bubble_q, any_bubble);
        if (term) begin
          state_d = S_DONE;
          final_d = W_stat_i;
        end
`ifdef PIPE_RUN_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = S_DONE;
          final_d = 3'd5;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= 4'd0;
      final_q     <= 3'd0;
      cycle_q     <= '0;
      instr_q     <= '0;
      stall_q     <= '0;
      bubble_q    <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      final_q     <= final_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
    end
  end

  assign run_o        = (state_q == S_RUN);
  assign flush_o      = (state_q == S_FLUSH);
  assign done_o       = (state_q == S_DONE);
  assign state_o      = state_q;
  assign final_stat_o = final_q;
  assign cycle_cnt_o  = cycle_q;
  assign instr_cnt_o  = instr_q;
  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;

endmodule

// File: doc/pipe_run_ctrl.md
PIPE_RUN_CTRL -- requirements
Module: pipe_run_ctrl

Interface
REQ-001 Parameter STAGES, default 5: number of pipeline stages flushed at start; legal range 1..15.
REQ-002 Parameter CNT_W, default 32: width of every statistics counter; legal range 8..64.
REQ-003 Parameter TIMEOUT, default 1000: watchdog limit in RUN cycles; used only with PIPE_RUN_TIMEOUT_EN.
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 start_i  input  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
REQ-007 W_stat_i  input  3  writeback status: 0 bubble, 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-008 W_icode_i  input  4  writeback icode; 4'h1 = nop.
REQ-009 D_stall_i  input  1  decode-stage stall from pipeline control.
REQ-010 D_bubble_i, E_bubble_i, M_bubble_i  input  1 each  per-stage bubble requests from pipeline control.
REQ-011 run_o  output  1  pipeline enable; 1 only in RUN.
REQ-012 flush_o  output  1  force bubble into all pipe registers; 1 only in FLUSH.
REQ-013 done_o  output  1  run finished; 1 only in DONE.
REQ-014 state_o  output  2  00 IDLE, 01 FLUSH, 10 RUN, 11 DONE.
REQ-015 final_stat_o  output  3  status that ended the last run; 5 = timeout.
REQ-016 cycle_cnt_o, instr_cnt_o, stall_cnt_o, bubble_cnt_o  output  CNT_W each  run statistics.

Function
REQ-017 IDLE: start_i=1 -> FLUSH next cycle; all counters and final_stat_o cleared to 0 on that same edge.
REQ-018 FLUSH: flush_o=1, run_o=0 for exactly STAGES cycles, then RUN; start_i ignored.
REQ-019 RUN: run_o=1; cycle_cnt_o += 1 every RUN cycle, including the terminating one.
REQ-020 RUN: instr_cnt_o += 1 in any cycle with W_stat_i=1 and W_icode_i!=4'h1, or W_stat_i=2.
REQ-021 RUN: stall_cnt_o += 1 per cycle with D_stall_i=1; bubble_cnt_o += 1 per cycle with any of D/E/M_bubble_i=1 (one per cycle, not per stage).
REQ-022 RUN -> DONE on the edge where W_stat_i is 2, 3 or 4; final_stat_o latches W_stat_i on that edge.
REQ-023 W_stat_i values 0, 1, 5, 6, 7 never terminate a run; 5..7 are treated as bubble for counting.
REQ-024 DONE: run_o=0, done_o=1, all counters and final_stat_o frozen; start_i=1 -> FLUSH with counters cleared as in REQ-017.
REQ-025 start_i during FLUSH or RUN has no effect.
REQ-026 All counters saturate at 2^CNT_W-1 and never wrap.
REQ-027 Outputs are registered or decoded only from registered state; no combinational path from any input to any output.

Reset
REQ-028 rst_n_i=0 forces IDLE immediately, asynchronously, from any state, including mid-FLUSH or mid-RUN.
REQ-029 Reset values: run_o=0, flush_o=0, done_o=0, state_o=00, final_stat_o=0, all counters 0, flush cycle counter 0.
REQ-030 First start_i is sampled on the first rising edge after rst_n_i deasserts.

Configuration
REQ-031 Macro PIPE_RUN_TIMEOUT_EN defined: when cycle_cnt_o would reach TIMEOUT in RUN, RUN -> DONE with final_stat_o=5.
REQ-032 With PIPE_RUN_TIMEOUT_EN, a terminating W_stat_i on the timeout cycle wins; final_stat_o takes W_stat_i.
REQ-033 Macro undefined: no watchdog logic; final_stat_o never equals 5; TIMEOUT unused.

Verification
REQ-034 Reset, start_i pulse, STAGES=5 -> flush_o high exactly 5 cycles, then run_o=1, state_o=10.
REQ-035 RUN with 7 AOK non-nop retirements, 2 nops, then W_stat_i=2 -> instr_cnt_o=8, final_stat_o=2, done_o=1, cycle_cnt_o=10.
REQ-036 RUN, D_stall_i high 3 cycles, D_bubble_i and E_bubble_i both high in one same cycle -> stall_cnt_o=3, bubble_cnt_o=1.
REQ-037 rst_n_i pulled low mid-RUN, asynchronous to clk_i -> state_o=00 and all counters 0 before next edge.
REQ-038 CNT_W=8, 300 AOK retirements without termination -> instr_cnt_o holds 255.
REQ-039 PIPE_RUN_TIMEOUT_EN, TIMEOUT=20, W_stat_i held 1 -> DONE after 20 RUN cycles, final_stat_o=5; repeat with W_stat_i=3 on cycle 20 -> final_stat_o=3.
